// File: rtl/ext_port_host.sv
// ext_port_host -- host-side peer of the SCPU external port.
//
// An input FIFO buffers host bytes and presents its head on the CPU ext_in
// bus; the CPU pops one entry per IN (cpu_in_ack). An output FIFO captures
// every byte the CPU strobes out on ext_out; the host drains it with a
// valid/ready handshake. The CPU side can never stall, so an ack on an
// empty input FIFO and a strobe into a full output FIFO are recorded in
// sticky error flags instead of being back-pressured.
//
// Ports:
//   clk, rst                         clock; async reset, active low
//   host_wr_data/valid/ready         host -> input FIFO push
//   cpu_ext_in, cpu_in_empty         input FIFO head seen by the CPU
//   cpu_in_ack                       CPU consumed cpu_ext_in (pop)
//   cpu_ext_out, cpu_out_stb         CPU byte -> output FIFO push
//   host_rd_data/valid/ready         output FIFO head -> host
//   in_level, out_level              FIFO occupancies
//   err_underflow, err_overflow      sticky error flags
//   stat_in_words, stat_out_words    saturating counters (EXT_PORT_STATS_EN)
//   clr_err                          sync clear of flags and counters
//
// Build option: define EXT_PORT_STATS_EN to add the statistics counters.
module ext_port_host #(
  parameter int          IN_DEPTH   = 4,
  parameter int          OUT_DEPTH  = 4,
  parameter logic [7:0]  IDLE_VALUE = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] host_wr_data,
  input  logic       host_wr_valid,
  output logic       host_wr_ready,
  output logic [7:0] cpu_ext_in,
  output logic       cpu_in_empty,
  input  logic       cpu_in_ack,
  input  logic [7:0] cpu_ext_out,
  input  logic       cpu_out_stb,
  output logic [7:0] host_rd_data,
  output logic       host_rd_valid,
  input  logic       host_rd_ready,
  output logic [4:0] in_level,
  output logic [4:0] out_level,
  output logic       err_underflow,
  output logic       err_overflow,
`ifdef EXT_PORT_STATS_EN
  output logic [7:0] stat_in_words,
  output logic [7:0] stat_out_words,
`endif
  input  logic       clr_err
);
  localparam int IPW = (IN_DEPTH  > 1) ? $clog2(IN_DEPTH)  : 1;
  localparam int OPW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

  // ---------------- input FIFO (host -> CPU) ----------------
  logic [7:0]     in_mem [IN_DEPTH];
  logic [IPW-1:0] in_wr_ptr, in_rd_ptr;
  logic           in_push, in_pop, in_uflow;

  assign host_wr_ready = (in_level != 5'(IN_DEPTH));
  assign cpu_in_empty  = (in_level == 5'd0);
  assign cpu_ext_in    = cpu_in_empty ? IDLE_VALUE : in_mem[in_rd_ptr];
  assign in_push       = host_wr_valid && host_wr_ready;
  // Pop/underflow judged on the pre-edge level: an ack in the same cycle as
  // the first push into an empty FIFO is an underflow, the push still lands.
  assign in_pop        = cpu_in_ack && !cpu_in_empty;
  assign in_uflow      = cpu_in_ack &&  cpu_in_empty;

  always_ff @(posedge clk) begin
    if (in_push) in_mem[in_wr_ptr] <= host_wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_wr_ptr <= '0;
      in_rd_ptr <= '0;
      in_level  <= '0;
    end else begin
      if (in_push) in_wr_ptr <= in_wr_ptr + IPW'(1);
      if (in_pop)  in_rd_ptr <= in_rd_ptr + IPW'(1);
      case ({in_push, in_pop})
        2'b10:   in_level <= in_level + 5'd1;
        2'b01:   in_level <= in_level - 5'd1;
        default: ;
      endcase
    end
  end

  // ---------------- output FIFO (CPU -> host) ----------------
  logic [7:0]     out_mem [OUT_DEPTH];
  logic [OPW-1:0] out_wr_ptr, out_rd_ptr;
  logic           out_full, out_push, out_pop, out_oflow;

  assign out_full      = (out_level == 5'(OUT_DEPTH));
  assign host_rd_valid = (out_level != 5'd0);
  assign host_rd_data  = host_rd_valid ? out_mem[out_rd_ptr] : 8'h00;
  assign out_pop       = host_rd_valid && host_rd_ready;
  // A pop in the same cycle frees the slot, so full+strobe+pop is accepted.
  assign out_push      = cpu_out_stb && (!out_full || out_pop);
  assign out_oflow     = cpu_out_stb &&   out_full && !out_pop;

  always_ff @(posedge clk) begin
    if (out_push) out_mem[out_wr_ptr] <= cpu_ext_out;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_wr_ptr <= '0;
      out_rd_ptr <= '0;
      out_level  <= '0;
    end else begin
      if (out_push) out_wr_ptr <= out_wr_ptr + OPW'(1);
      if (out_pop)  out_rd_ptr <= out_rd_ptr + OPW'(1);
      case ({out_push, out_pop})
        2'b10:   out_level <= out_level + 5'd1;
        2'b01:   out_level <= out_level - 5'd1;
        default: ;
      endcase
    end
  end

  // ---------------- sticky flags: a new event beats clr_err ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_underflow <= 1'b0;
      err_overflow  <= 1'b0;
    end else begin
      err_underflow <= in_uflow  || (err_underflow && !clr_err);
      err_overflow  <= out_oflow || (err_overflow  && !clr_err);
    end
  end

`ifdef EXT_PORT_STATS_EN
  // Saturating traffic counters; clr_err zeroes them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_in_words  <= '0;
      stat_out_words <= '0;
    end else if (clr_err) begin
      stat_in_words  <= '0;
      stat_out_words <= '0;
    end else begin
      if (in_pop  && stat_in_words  != 8'hFF) stat_in_words  <= stat_in_words  + 8'd1;
      if (out_push && stat_out_words != 8'hFF) stat_out_words <= stat_out_words + 8'd1;
    end
  end
`else
  // Statistics counters not built.
`endif

endmodule
